// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN multi-core subsystem (core count, prediction width, FSM states).
package cnn_pkg;

  localparam int unsigned CNN_N_CORES   = 4;
  localparam int unsigned CNN_OUT_WIDTH = 32;

  typedef logic [CNN_OUT_WIDTH-1:0] pred_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cnn_result_collector.sv
// Collects per-core CNN predictions for one batch and drains them in core-index
// order as a valid/ready stream, marking cores that miss the batch timeout.
module cnn_result_collector
  import cnn_pkg::*;
#(
  parameter int unsigned N_CORES   = CNN_N_CORES,
  parameter int unsigned OUT_WIDTH = CNN_OUT_WIDTH,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned IDX_W     = $clog2(N_CORES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CORES-1:0]           core_done,
  input  logic [N_CORES*OUT_WIDTH-1:0] core_pred,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [OUT_WIDTH-1:0]         m_data,
  output logic [IDX_W-1:0]             m_idx,
  output logic                         m_last,
  output logic                         m_err,
  output logic                         busy,
  output logic                         all_done,
  output logic                         timeout
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CORES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_CORES-1:0]   r_captured;
  logic [N_CORES-1:0]   r_failed;
  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_timeout;
  logic [OUT_WIDTH-1:0] r_buf [N_CORES];

  logic                 w_run;
  logic                 w_valid;
  logic                 w_hs;
  logic                 w_last_hs;
  logic                 w_open;
  logic                 w_tmo_hit;
  logic [N_CORES-1:0]   w_new_cap;
  logic [N_CORES-1:0]   w_new_fail;

  // Handshake, capture and timeout qualifiers derived from registered state.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_valid    = w_run && r_captured[r_ptr];
    w_hs       = w_valid && m_ready;
    w_last_hs  = w_hs && (r_ptr == IDX_LAST);
    w_open     = !w_run && start;
    w_new_cap  = w_run ? (core_done & ~r_captured) : '0;
    w_tmo_hit  = w_run && (r_cnt == CNT_MAX);
    // A core whose done arrives on the timeout edge is captured, not failed.
    w_new_fail = w_tmo_hit ? ~(r_captured | core_done) : '0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic: start is only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)     w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_hs) w_state_nxt = ST_DONE;
      ST_DONE: if (start)     w_state_nxt = ST_RUN;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Batch bookkeeping: capture/failed masks, read pointer, cycle counter, sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_captured <= '0;
      r_failed   <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else if (w_open) begin
      r_captured <= '0;
      r_failed   <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else if (w_run) begin
      r_captured <= r_captured | w_new_cap | w_new_fail;
      r_failed   <= r_failed | w_new_fail;
      if (|w_new_fail) r_timeout <= 1'b1;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      // Wrap after the last beat so the pointer never leaves the buffer range.
      if (w_hs) r_ptr <= (r_ptr == IDX_LAST) ? '0 : r_ptr + IDX_W'(1);
    end
  end

  // Prediction buffers: first capture per batch wins; contents need no reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (w_new_cap[k]) r_buf[k] <= core_pred[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // Stream outputs come straight from registers through one read mux.
  always_comb begin
    m_valid  = w_valid;
    m_idx    = r_ptr;
    m_last   = (r_ptr == IDX_LAST);
    m_err    = w_valid && r_failed[r_ptr];
    m_data   = (w_valid && !r_failed[r_ptr]) ? r_buf[r_ptr] : '0;
    busy     = w_run;
    all_done = (r_state == ST_DONE);
    timeout  = r_timeout;
  end

endmodule
